// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state
// encoding, oversampling ratio and the default 100 MHz / 19200 baud divisor.
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } tx_state_t;

   localparam int OVERSAMPLE     = 16;
   localparam int DEFAULT_DVSR   = 326;
   localparam int DEFAULT_DVSR_W = 9;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick generator: one s_tick every DVSR clocks.
// Only the global reset restarts it, so the transmitter never re-phases it.
module baud_gen
   import uart_tx_fifo_pkg::*;
#(
   parameter int DVSR   = DEFAULT_DVSR,
   parameter int DVSR_W = DEFAULT_DVSR_W
) (
   input  logic clk,
   input  logic rst,
   output logic s_tick
);

   localparam logic [DVSR_W-1:0] LAST_COUNT = DVSR_W'(DVSR - 1);

   logic [DVSR_W-1:0] count;

   // Modulo-DVSR counter; wraps to zero on the clock where the tick is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count == LAST_COUNT) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign s_tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and
// sends each one as start bit, DBIT data bits LSB-first, then a stop bit.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = DEFAULT_DVSR,
   parameter int DVSR_W  = DEFAULT_DVSR_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick
);

   localparam logic [4:0] LAST_OS_TICK   = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] LAST_STOP_TICK = 5'(SB_TICK - 1);
   localparam logic [2:0] LAST_BIT       = 3'(DBIT - 1);

   tx_state_t       state_reg, state_next;
   logic [4:0]      tick_reg, tick_next;
   logic [2:0]      bit_reg, bit_next;
   logic [DBIT-1:0] shift_reg, shift_next;
   logic            tx_reg, tx_next;
   logic            s_tick;

   baud_gen #(
      .DVSR   (DVSR),
      .DVSR_W (DVSR_W)
   ) u_baud_gen (
      .clk    (clk),
      .rst    (rst),
      .s_tick (s_tick)
   );

   // State and datapath registers; an aborted byte is simply dropped on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

   // Next-state logic; the line level follows the next state so tx changes on the same edge as the FSM.
   always_comb begin
      state_next   = state_reg;
      tick_next    = tick_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      fifo_rd      = 1'b0;
      tx_done_tick = 1'b0;
      tx_next      = 1'b1;

      unique case (state_reg)
         IDLE: begin
            if (!fifo_empty && !rst) begin
               fifo_rd    = 1'b1;
               shift_next = fifo_rd_data[DBIT-1:0];
               tick_next  = '0;
               state_next = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (tick_reg == LAST_OS_TICK) begin
                  tick_next  = '0;
                  bit_next   = '0;
                  state_next = DATA;
               end else begin
                  tick_next = tick_reg + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (tick_reg == LAST_OS_TICK) begin
                  tick_next  = '0;
                  shift_next = shift_reg >> 1;
                  if (bit_reg == LAST_BIT) begin
                     state_next = STOP;
                  end else begin
                     bit_next = bit_reg + 3'd1;
                  end
               end else begin
                  tick_next = tick_reg + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (tick_reg == LAST_STOP_TICK) begin
                  tx_done_tick = 1'b1;
                  state_next   = IDLE;
               end else begin
                  tick_next = tick_reg + 5'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      unique case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Two instances share clock and reset:
// A is 8N1 (DBIT=8, SB_TICK=16), B is 7 data bits with 2 stop bits
// (DBIT=7, SB_TICK=32). Both use DVSR=4, so one bit lasts 64 clocks.
// Each instance is fed by a small array-based FIFO model owned by the bench.
module tb_uart_tx_fifo;

   localparam int BIT_CLK = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       empty_a, rd_a, tx_a, busy_a, done_a;
   logic [7:0] data_a;
   logic       empty_b, rd_b, tx_b, busy_b, done_b;
   logic [7:0] data_b;

   logic [7:0] mem_a [64];
   logic [7:0] mem_b [64];
   int wr_a = 0, pop_a = 0, bad_a = 0, done_cnt_a = 0;
   int wr_b = 0, pop_b = 0, bad_b = 0, done_cnt_b = 0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // FWFT FIFO model: head word is visible whenever the model holds data.
   assign empty_a = (wr_a == pop_a);
   assign data_a  = mem_a[pop_a[5:0]];
   assign empty_b = (wr_b == pop_b);
   assign data_b  = mem_b[pop_b[5:0]];

   // Consume pops, flag pops from an empty FIFO and count completed frames.
   always @(posedge clk) begin
      if (rd_a) begin
         pop_a <= pop_a + 1;
         if (empty_a) bad_a <= bad_a + 1;
      end
      if (rd_b) begin
         pop_b <= pop_b + 1;
         if (empty_b) bad_b <= bad_b + 1;
      end
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
   end

   uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(2)) dut_a (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (empty_a),
      .fifo_rd_data (data_a),
      .fifo_rd      (rd_a),
      .tx           (tx_a),
      .tx_busy      (busy_a),
      .tx_done_tick (done_a)
   );

   uart_tx_fifo #(.DBIT(7), .SB_TICK(32), .DVSR(4), .DVSR_W(2)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (empty_b),
      .fifo_rd_data (data_b),
      .fifo_rd      (rd_b),
      .tx           (tx_b),
      .tx_busy      (busy_b),
      .tx_done_tick (done_b)
   );

   function automatic logic line_tx(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic line_busy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   function automatic logic line_done(input bit sel);
      return sel ? done_b : done_a;
   endfunction

   // Queue one byte into the selected FIFO model.
   task automatic applyStimulus(input bit sel, input logic [7:0] val);
      if (sel) begin
         mem_b[wr_b % 64] = val;
         wr_b++;
      end else begin
         mem_a[wr_a % 64] = val;
         wr_a++;
      end
   endtask

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Receive one frame from the line and compare it to the ideal UART frame.
   // Bits are sampled 32 clocks into each nominal bit; the stop length is
   // recovered from the final run of high line cycles minus the trailing
   // one-valued data bits, which all sit on exact 64-clock boundaries.
   task automatic check_frame(input bit sel, input logic [7:0] b, input int dbit,
                              input int sb_tick, input string tag, output int wait_cycles);
      int k, run, ones, limit;
      bit done_seen;
      k = 0;
      while (line_tx(sel) !== 1'b0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      wait_cycles = k;
      checkBit($sformatf("%s_start_seen", tag), line_tx(sel), 1'b0);
      if (line_tx(sel) !== 1'b0) return;
      ones = 0;
      for (int i = dbit - 1; i >= 0; i--) begin
         if (b[i] !== 1'b1) break;
         ones++;
      end
      run       = 0;
      done_seen = 1'b0;
      limit     = (dbit + 2) * BIT_CLK + sb_tick * 4 + BIT_CLK;
      for (int n = 0; n < limit && !done_seen; n++) begin
         if (n > 0) @(negedge clk);
         run = (line_tx(sel) === 1'b1) ? run + 1 : 0;
         if (n % BIT_CLK == 32 && n / BIT_CLK <= dbit) begin
            if (n / BIT_CLK == 0)
               checkBit($sformatf("%s_startbit", tag), line_tx(sel), 1'b0);
            else
               checkBit($sformatf("%s_bit%0d", tag, n / BIT_CLK - 1), line_tx(sel),
                        b[n / BIT_CLK - 1]);
         end
         if (n == 96 + BIT_CLK * dbit)
            checkBit($sformatf("%s_stop_mid", tag), line_tx(sel), 1'b1);
         if (line_done(sel) === 1'b1) begin
            done_seen = 1'b1;
            checkOutput($sformatf("%s_stop_len", tag), run - BIT_CLK * ones, sb_tick * 4);
         end
      end
      checkBit($sformatf("%s_done_seen", tag), done_seen, 1'b1);
      @(negedge clk);
      checkBit($sformatf("%s_after_busy", tag), line_busy(sel), 1'b0);
      checkBit($sformatf("%s_after_tx", tag), line_tx(sel), 1'b1);
   endtask

   // Directed sequence with randomized payloads.
   initial begin
      int w, bad_idle;
      logic [7:0] r, nb;
      logic [7:0] rnd [4];

      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end

      // Reset held with data waiting: line idle, no pop, not busy.
      rst = 1'b1;
      r = 8'($urandom_range(0, 255));
      applyStimulus(0, r);
      repeat (5) begin
         @(negedge clk);
         checkBit("rst_tx", tx_a, 1'b1);
         checkBit("rst_rd", rd_a, 1'b0);
         checkBit("rst_busy", busy_a, 1'b0);
      end
      rst = 1'b0;
      #1 checkBit("rel_rd", rd_a, 1'b1);
      @(posedge clk);
      #1;
      checkBit("rel_busy", busy_a, 1'b1);
      checkBit("rel_rd_drop", rd_a, 1'b0);
      @(negedge clk);
      check_frame(0, r, 8, 16, "first", w);

      // Single directed byte.
      applyStimulus(0, 8'hA5);
      check_frame(0, 8'hA5, 8, 16, "a5", w);

      // Two queued bytes go out back to back with a one-clock gap.
      applyStimulus(0, 8'h00);
      applyStimulus(0, 8'hFF);
      check_frame(0, 8'h00, 8, 16, "b2b0", w);
      check_frame(0, 8'hFF, 8, 16, "b2b1", w);
      checkOutput("b2b_gap", w, 1);

      // Empty FIFO for 2000 clocks: nothing happens.
      bad_idle = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || rd_a !== 1'b0 || busy_a !== 1'b0) bad_idle++;
      end
      checkOutput("idle_line", bad_idle, 0);
      checkOutput("idle_pops", pop_a, wr_a);
      checkOutput("idle_done", done_cnt_a, 4);

      // Random burst of four bytes.
      for (int i = 0; i < 4; i++) begin
         rnd[i] = 8'($urandom_range(0, 255));
         applyStimulus(0, rnd[i]);
      end
      for (int i = 0; i < 4; i++) begin
         check_frame(0, rnd[i], 8, 16, $sformatf("rnd%0d", i), w);
         if (i > 0) checkOutput($sformatf("rnd%0d_gap", i), w, 1);
      end

      // Reset in the middle of data bit 3 of 0x5A; the next byte follows intact.
      nb = 8'($urandom_range(0, 255));
      if (nb == 8'h5A) nb = 8'h3C;
      applyStimulus(0, 8'h5A);
      applyStimulus(0, nb);
      w = 0;
      while (tx_a !== 1'b0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      repeat (288) @(negedge clk);
      checkBit("abort_bit3", tx_a, 1'b1);
      checkBit("abort_busy_pre", busy_a, 1'b1);
      rst = 1'b1;
      #1;
      checkBit("abort_tx", tx_a, 1'b1);
      checkBit("abort_busy", busy_a, 1'b0);
      checkBit("abort_rd", rd_a, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_repop", pop_a, wr_a - 1);
      rst = 1'b0;
      #1 checkBit("abort_rel_rd", rd_a, 1'b1);
      @(negedge clk);
      check_frame(0, nb, 8, 16, "after_abort", w);

      // Seven data bits, two stop bits.
      applyStimulus(1, 8'hC3);
      check_frame(1, 8'hC3, 7, 32, "b_c3", w);
      r = 8'($urandom_range(0, 255));
      applyStimulus(1, r);
      check_frame(1, r, 7, 32, "b_rnd", w);

      // Bookkeeping: every queued byte popped once, none from empty, one done per frame.
      checkOutput("a_pops", pop_a, wr_a);
      checkOutput("b_pops", pop_b, wr_b);
      checkOutput("a_empty_pops", bad_a, 0);
      checkOutput("b_empty_pops", bad_b, 0);
      checkOutput("a_done_count", done_cnt_a, 9);
      checkOutput("b_done_count", done_cnt_b, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
